exp_taylor_seq: RTL
===================

EXP_TAYLOR_SEQ -- requirements
Module: exp_taylor_seq

Interface
REQ-001 Parameter WIDTH, default 32, data/result width in bits (unsigned, fixed-point value = integer/SCALE).
REQ-002 Parameter SCALE, default 1000, fixed-point scale factor (1.0 == SCALE).
REQ-003 Parameter TERMS, default 20, maximum Taylor terms including the constant term; legal range 2..64.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 x  input  WIDTH  exponent argument, scaled by SCALE; latched on accepted start.
REQ-008 busy  output  1  high while a computation is in progress (CALC or DONE state).
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 result  output  WIDTH  scaled e^x, held from done until next accepted start.
REQ-011 overflow  output  1  sticky per computation; set if any term or partial sum saturated.

Function
REQ-012 FSM states IDLE, CALC, DONE; IDLE -> CALC on start; CALC -> DONE after last iteration; DONE -> IDLE unconditionally after one cycle.
REQ-013 On accepted start: x_r <= x, term <= SCALE, sum <= SCALE, i <= 1, overflow <= 0.
REQ-014 Each CALC cycle: term <= (term*x_r)/(i*SCALE) (truncating, product 2*WIDTH bits wide); sum <= sum + new term; i <= i+1.
REQ-015 CALC ends after iteration i = TERMS-1; latency start-edge to done-high = TERMS cycles (without early exit).
REQ-016 Term or sum exceeding 2^WIDTH-1 saturates to 2^WIDTH-1 and sets overflow; after saturation iteration continues unchanged.
REQ-017 result and overflow update at CALC->DONE transition; done high exactly in DONE.
REQ-018 start while busy ignored; x changes while busy ignored.
REQ-019 start asserted in DONE cycle ignored; accepted next cycle in IDLE if still high.
REQ-020 x = 0 is legal: result = SCALE.

Reset
REQ-021 rst asserted at any time (incl. mid-CALC): state IDLE, busy 0, done 0, result 0, overflow 0, internal term/sum/i cleared; in-flight computation discarded, no done.
REQ-022 First start accepted on the first rising edge after rst deasserts.

Configuration
REQ-023 Macro EXP_EARLY_EXIT_EN defined: CALC -> DONE also when the newly computed term is 0 (that iteration's sum still committed); latency = (iterations used)+1.
REQ-024 EXP_EARLY_EXIT_EN undefined: always TERMS-1 iterations, fixed latency TERMS.

Structure
REQ-025 Package exp_pkg holds the state enum typedef and default constants (DEF_WIDTH, DEF_SCALE, DEF_TERMS).
REQ-026 Sub-module exp_term_step: combinational multiply/divide/saturate of one term (inputs term, x, i; outputs next term, sat flag); instantiated once.

Verification
REQ-027 Defaults, x=1000 -> result 2716, overflow 0, done 20 cycles after start (early exit: 8 cycles).
REQ-028 Defaults, x=3000 -> result 20082, overflow 0.
REQ-029 Defaults, x=0 -> result 1000, overflow 0 (early exit: done 2 cycles after start).
REQ-030 WIDTH=16, x=20000 -> result 0xFFFF, overflow 1.
REQ-031 rst pulse 5 cycles into CALC -> no done, outputs 0; new start x=1000 -> 2716.
REQ-032 start held high continuously, x toggled during busy -> back-to-back runs use x sampled in IDLE only; done pulses exactly once per run.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared types and default constants for the sequential Taylor-series e^x block.
package exp_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SCALE = 1000;
  localparam int DEF_TERMS = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/exp_term_step.sv
// One Taylor step: next = (term * x) / (idx * SCALE), truncated, saturated to WIDTH bits.
module exp_term_step #(
  parameter int WIDTH = 32,
  parameter int SCALE = 1000,
  parameter int IW    = 7
) (
  input  logic [WIDTH-1:0] i_term,
  input  logic [WIDTH-1:0] i_x,
  input  logic [IW-1:0]    i_idx,
  output logic [WIDTH-1:0] o_term,
  output logic             o_sat
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_div;
  logic [PW-1:0] w_div_safe;
  logic [PW-1:0] w_quot;

  assign w_prod     = PW'(i_term) * PW'(i_x);
  assign w_div      = PW'(i_idx) * PW'(SCALE);
  // idx is 0 only while idle after reset, where the step output is unused
  assign w_div_safe = (w_div == '0) ? PW'(1) : w_div;
  assign w_quot     = w_prod / w_div_safe;

  assign o_sat  = |w_quot[PW-1:WIDTH];
  assign o_term = o_sat ? '1 : w_quot[WIDTH-1:0];

endmodule

// File: rtl/exp_taylor_seq.sv
// Sequential fixed-point e^x via Taylor series, one term per cycle.
// Optional EXP_EARLY_EXIT_EN: finish as soon as a computed term reaches zero.
module exp_taylor_seq
  import exp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SCALE = DEF_SCALE,
  parameter int TERMS = DEF_TERMS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int IW = 7;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_term;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_i;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;

  logic [WIDTH-1:0] w_term;
  logic             w_term_sat;
  logic [WIDTH:0]   w_sum_ext;
  logic             w_sum_sat;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf_next;
  logic             w_last;
  logic             w_finish;

  exp_term_step #(
    .WIDTH (WIDTH),
    .SCALE (SCALE),
    .IW    (IW)
  ) u_step (
    .i_term (r_term),
    .i_x    (r_x),
    .i_idx  (r_i),
    .o_term (w_term),
    .o_sat  (w_term_sat)
  );

  assign w_sum_ext  = {1'b0, r_sum} + {1'b0, w_term};
  assign w_sum_sat  = w_sum_ext[WIDTH];
  assign w_sum      = w_sum_sat ? '1 : w_sum_ext[WIDTH-1:0];
  assign w_ovf_next = r_ovf | w_term_sat | w_sum_sat;
  assign w_last     = (r_i == IW'(TERMS - 1));

`ifdef EXP_EARLY_EXIT_EN
  assign w_finish = w_last || (w_term == '0);
`else
  assign w_finish = w_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_term     <= '0;
      r_sum      <= '0;
      r_i        <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x        <= x;
            r_term     <= WIDTH'(SCALE);
            r_sum      <= WIDTH'(SCALE);
            r_i        <= IW'(1);
            r_ovf      <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_term <= w_term;
          r_sum  <= w_sum;
          r_i    <= r_i + IW'(1);
          r_ovf  <= w_ovf_next;
          if (w_finish) begin
            r_result   <= w_sum;
            r_overflow <= w_ovf_next;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule
